// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register-count constants and the address type
// for the two-read/one-write register file.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Architectural zero register (XZR): never stored, always reads 0.
  localparam reg_addr_t ZERO_REG = 5'd31;

endpackage : regfile_pkg

// File: rtl/regfile_read_mux32_1.sv
// mux32_1: combinational 32:1 selector of WIDTH-bit words.
// Ports:
//   in  - 32 packed WIDTH-bit inputs, index 0..31
//   sel - 5-bit select
//   out - in[sel]
module mux32_1
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [NUM_REGS-1:0][WIDTH-1:0] in,
  input  reg_addr_t                      sel,
  output logic [WIDTH-1:0]               out
);

  assign out = in[sel];

endmodule : mux32_1

// File: rtl/register.sv
// register: WIDTH-bit storage element with write enable.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high clear
//   enable - load d on the next rising edge
//   d      - data in
//   q      - stored value
module register #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset takes priority over any pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule : register

// File: rtl/regfile_read.sv
// regfile_read: 32 x WIDTH register file, two asynchronous read ports and one
// synchronous write port, with X31 hard-wired to zero and write-to-read bypass
// so a write presented this cycle is visible on the read ports immediately.
// Ports:
//   clk, reset                   - clock, synchronous active-high clear
//   ReadRegister1/ReadRegister2  - read port addresses
//   WriteRegister, WriteData     - write port address and data
//   RegWrite                     - write enable
//   ReadData1/ReadData2          - combinational read data (bypassed)
module regfile_read
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  reg_addr_t        ReadRegister1,
  input  reg_addr_t        ReadRegister2,
  input  reg_addr_t        WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             RegWrite,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  // A write is live only outside reset and never for XZR; this gates both
  // the decoder and the bypass.
  logic wr_active;
  assign wr_active = RegWrite && !reset && (WriteRegister != ZERO_REG);

  logic [NREGS-2:0]            wr_en;
  logic [NREGS-1:0][WIDTH-1:0] regs;

  // One-hot write decode and storage for X0..X30.
  for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
    assign wr_en[i] = wr_active && (WriteRegister == REG_ADDR_W'(i));

    register #(
      .WIDTH(WIDTH)
    ) u_register (
      .clk   (clk),
      .reset (reset),
      .enable(wr_en[i]),
      .d     (WriteData),
      .q     (regs[i])
    );
  end

  assign regs[NREGS-1] = '0;

  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  mux32_1 #(
    .WIDTH(WIDTH)
  ) u_mux1 (
    .in (regs),
    .sel(ReadRegister1),
    .out(stored1)
  );

  mux32_1 #(
    .WIDTH(WIDTH)
  ) u_mux2 (
    .in (regs),
    .sel(ReadRegister2),
    .out(stored2)
  );

  // Bypass: forward the in-flight write to any port reading the same address.
  assign ReadData1 = (wr_active && (ReadRegister1 == WriteRegister)) ? WriteData : stored1;
  assign ReadData2 = (wr_active && (ReadRegister2 == WriteRegister)) ? WriteData : stored2;

endmodule : regfile_read

// File: tb/tb_regfile_read.sv
// tb_regfile_read: directed self-checking bench for regfile_read.
module tb_regfile_read;
  import regfile_pkg::*;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             reset;
  reg_addr_t        ReadRegister1;
  reg_addr_t        ReadRegister2;
  reg_addr_t        WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic             RegWrite;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_read #(
    .WIDTH(WIDTH),
    .NREGS(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled #1 later,
  // well away from the rising edge.

  task automatic test_reset();
    @(negedge clk);
    reset    = 1'b1;
    RegWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(31 - a);
      #1;
      n_checks++;
      if (ReadData1 !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_rd1 addr=%0d: got %h expected %h", a, ReadData1, 64'h0);
      end
      n_checks++;
      if (ReadData2 !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_rd2 addr=%0d: got %h expected %h", 31 - a, ReadData2, 64'h0);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    WriteRegister = 5'd5;
    WriteData     = 64'hDEAD_BEEF_0000_0001;
    RegWrite      = 1'b1;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteData     = 64'h0;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd6;
    #1;
    n_checks++;
    if (ReadData1 !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL write_x5: got %h expected %h", ReadData1, 64'hDEAD_BEEF_0000_0001);
    end
    n_checks++;
    if (ReadData2 !== 64'h0) begin
      n_fail++;
      $display("FAIL read_x6: got %h expected %h", ReadData2, 64'h0);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    WriteRegister = 5'd31;
    WriteData     = 64'h1234;
    RegWrite      = 1'b1;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd31;
    #1;
    n_checks++;
    if (ReadData1 !== 64'h0) begin
      n_fail++;
      $display("FAIL xzr_same_cycle: got %h expected %h", ReadData1, 64'h0);
    end
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    n_checks++;
    if (ReadData2 !== 64'h0) begin
      n_fail++;
      $display("FAIL xzr_next_cycle: got %h expected %h", ReadData2, 64'h0);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    WriteRegister = 5'd7;
    WriteData     = 64'hAAAA;
    RegWrite      = 1'b1;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    #1;
    n_checks++;
    if (ReadData1 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL bypass_rd1: got %h expected %h", ReadData1, 64'hAAAA);
    end
    n_checks++;
    if (ReadData2 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL bypass_rd2: got %h expected %h", ReadData2, 64'hAAAA);
    end
    @(negedge clk);
    RegWrite  = 1'b0;
    WriteData = 64'h0;
    #1;
    n_checks++;
    if (ReadData1 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL stored_x7_rd1: got %h expected %h", ReadData1, 64'hAAAA);
    end
    n_checks++;
    if (ReadData2 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL stored_x7_rd2: got %h expected %h", ReadData2, 64'hAAAA);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    WriteRegister = 5'd3;
    WriteData     = 64'h55;
    RegWrite      = 1'b0;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd3;
    #1;
    n_checks++;
    if (ReadData1 !== 64'h0) begin
      n_fail++;
      $display("FAIL no_wen_bypass: got %h expected %h", ReadData1, 64'h0);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (ReadData1 !== 64'h0) begin
      n_fail++;
      $display("FAIL no_wen_store: got %h expected %h", ReadData1, 64'h0);
    end
    // Two writes on consecutive edges; the second wins.
    WriteData = 64'h11;
    RegWrite  = 1'b1;
    @(negedge clk);
    WriteData     = 64'h22;
    ReadRegister2 = 5'd4;
    #1;
    n_checks++;
    if (ReadData1 !== 64'h22) begin
      n_fail++;
      $display("FAIL b2b_bypass: got %h expected %h", ReadData1, 64'h22);
    end
    n_checks++;
    if (ReadData2 !== 64'h0) begin
      n_fail++;
      $display("FAIL b2b_other_port: got %h expected %h", ReadData2, 64'h0);
    end
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteData     = 64'h0;
    ReadRegister2 = 5'd3;
    #1;
    n_checks++;
    if (ReadData2 !== 64'h22) begin
      n_fail++;
      $display("FAIL b2b_last_wins: got %h expected %h", ReadData2, 64'h22);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] exp;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      WriteRegister = 5'(i);
      WriteData     = 64'(i * 32'h0101);
      RegWrite      = 1'b1;
    end
    @(negedge clk);
    RegWrite = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      ReadRegister1 = 5'(i);
      exp = 64'(i * 32'h0101);
      #1;
      n_checks++;
      if (ReadData1 !== exp) begin
        n_fail++;
        $display("FAIL load_x%0d: got %h expected %h", i, ReadData1, exp);
      end
    end
    // Reset together with a write to X2: the write is lost, bypass is off.
    @(negedge clk);
    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd2;
    WriteData     = 64'hFF;
    ReadRegister1 = 5'd2;
    ReadRegister2 = 5'd5;
    #1;
    n_checks++;
    if (ReadData1 !== 64'h0202) begin
      n_fail++;
      $display("FAIL reset_no_bypass: got %h expected %h", ReadData1, 64'h0202);
    end
    n_checks++;
    if (ReadData2 !== 64'h0505) begin
      n_fail++;
      $display("FAIL reset_before_edge: got %h expected %h", ReadData2, 64'h0505);
    end
    @(negedge clk);
    reset     = 1'b0;
    RegWrite  = 1'b0;
    WriteData = 64'h0;
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(a);
      #1;
      n_checks++;
      if (ReadData1 !== 64'h0) begin
        n_fail++;
        $display("FAIL post_reset_rd1 addr=%0d: got %h expected %h", a, ReadData1, 64'h0);
      end
      n_checks++;
      if (ReadData2 !== 64'h0) begin
        n_fail++;
        $display("FAIL post_reset_rd2 addr=%0d: got %h expected %h", a, ReadData2, 64'h0);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 64'h0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;

    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_read
